// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: signal bundle between the pattern generator and the VGA pins.
//   cmd          pattern select from the board switches (asynchronous to the pixel clock)
//   hsync/vsync  sync pulses, polarity set by the generator's SYNC_POL
//   de           active-video enable
//   vga_r/g/b    colour channels, COLOR_W bits each
//   pix_x/pix_y  active-pixel coordinates, 0 during blanking
//   frame_start  one-cycle pulse on the first sync cycle of each frame
//   led          currently applied mode
// Modports: master = generator side, slave = DAC/board side.
interface vga_pattern_gen_if #(
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9
);
    logic [2:0]         cmd;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic               frame_start;
    logic [2:0]         led;

    modport master (
        input  cmd,
        output hsync, vsync, de, vga_r, vga_g, vga_b, pix_x, pix_y, frame_start, led
    );

    modport slave (
        output cmd,
        input  hsync, vsync, de, vga_r, vga_g, vga_b, pix_x, pix_y, frame_start, led
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: programmable-timing VGA sync plus selectable test pattern.
// Line/frame order is sync, back porch, active, front porch. Every output is registered from
// the counter values of the previous cycle, so all outputs stay mutually aligned.
// Ports:
//   clk      pixel clock
//   reset_n  asynchronous active-low reset
//   vga      vga_pattern_gen_if.master (cmd in; sync, de, rgb, coordinates, frame_start, led out)
// Modes: 0 white, 1 red, 2 green, 3 blue, 4 vertical bars, 5 horizontal bands,
//        6 checkerboard, 7 grey ramp. The mode only changes at a frame boundary.
// Optional macro VGA_PATTERN_SCROLL_EN: adds a 16-bit frame counter and scrolls modes 4 and 6
// one pixel per frame. Without it the patterns are static and no frame counter exists.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned SYNC_POL  = 0,
    parameter int unsigned CELL_LOG2 = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    vga_pattern_gen_if.master  vga
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    // One spare count so the active-end bound is representable even with a zero front porch.
    localparam int unsigned HC_W    = $clog2(H_TOTAL + 1);
    localparam int unsigned VC_W    = $clog2(V_TOTAL + 1);

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] H_ACT_BEG  = HC_W'(H_SYNC + H_BACK);
    localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_ACT_BEG  = VC_W'(V_SYNC + V_BACK);
    localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(V_SYNC + V_BACK + V_ACTIVE);

    localparam int unsigned BAR_W      = H_ACTIVE / 4;
    localparam int unsigned BAND_H     = V_ACTIVE / 4;
    // Grey ramp takes the top COLOR_W bits of pix_x; a narrower pix_x is zero-extended.
    localparam int unsigned GREY_SHIFT = (X_W > COLOR_W) ? X_W - COLOR_W : 0;

    localparam logic SYNC_ON = (SYNC_POL != 0);

    localparam logic [COLOR_W-1:0]   FULL  = '1;
    localparam logic [COLOR_W-1:0]   NONE  = '0;
    localparam logic [3*COLOR_W-1:0] WHITE = {FULL, FULL, FULL};
    localparam logic [3*COLOR_W-1:0] RED   = {FULL, NONE, NONE};
    localparam logic [3*COLOR_W-1:0] GREEN = {NONE, FULL, NONE};
    localparam logic [3*COLOR_W-1:0] BLUE  = {NONE, NONE, FULL};
    localparam logic [3*COLOR_W-1:0] BLACK = '0;

    // Four equal regions red, blue, green, white; remainder falls into the white region.
    function automatic logic [3*COLOR_W-1:0] quad_colour(input int unsigned pos,
                                                         input int unsigned step);
        if (pos < step) begin
            return RED;
        end else if (pos < 2 * step) begin
            return BLUE;
        end else if (pos < 3 * step) begin
            return GREEN;
        end
        return WHITE;
    endfunction

    // Timing state
    logic [HC_W-1:0] hcount_q, hcount_d;
    logic [VC_W-1:0] vcount_q, vcount_d;

    // Mode path
    logic [2:0] cmd_meta_q, cmd_sync_q, mode_q;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [15:0] frame_cnt_q;
`endif

    // Registered outputs
    logic                 hsync_q, vsync_q, de_q, frame_start_q;
    logic [3*COLOR_W-1:0] rgb_q;
    logic [X_W-1:0]       pix_x_q;
    logic [Y_W-1:0]       pix_y_q;

    // Decode of the current counter values
    logic                 h_last, v_last, frame_first;
    logic                 h_sync_on, v_sync_on, h_act, v_act, act;
    logic [X_W-1:0]       x_d;
    logic [Y_W-1:0]       y_d;
    int unsigned          xi, yi, xs;
    logic [COLOR_W-1:0]   grey;
    logic [3*COLOR_W-1:0] rgb_d;

    always_comb begin
        h_last      = (hcount_q == H_LAST);
        v_last      = (vcount_q == V_LAST);
        frame_first = (hcount_q == '0) && (vcount_q == '0);

        hcount_d = h_last ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? '0 : vcount_q + 1'b1;
        end

        h_sync_on = (hcount_q < H_SYNC_END);
        v_sync_on = (vcount_q < V_SYNC_END);
        h_act     = (hcount_q >= H_ACT_BEG) && (hcount_q < H_ACT_END);
        v_act     = (vcount_q >= V_ACT_BEG) && (vcount_q < V_ACT_END);
        act       = h_act && v_act;

        x_d = act ? X_W'(hcount_q - H_ACT_BEG) : '0;
        y_d = act ? Y_W'(vcount_q - V_ACT_BEG) : '0;
        xi  = 32'(x_d);
        yi  = 32'(y_d);

`ifdef VGA_PATTERN_SCROLL_EN
        xs = (xi + 32'(frame_cnt_q[7:0])) % H_ACTIVE;
`else
        xs = xi;
`endif

        grey  = COLOR_W'(xi >> GREY_SHIFT);
        rgb_d = BLACK;
        unique case (mode_q)
            3'd0: rgb_d = WHITE;
            3'd1: rgb_d = RED;
            3'd2: rgb_d = GREEN;
            3'd3: rgb_d = BLUE;
            3'd4: rgb_d = quad_colour(xs, BAR_W);
            3'd5: rgb_d = quad_colour(yi, BAND_H);
            3'd6: rgb_d = ((((xs >> CELL_LOG2) ^ (yi >> CELL_LOG2)) & 32'd1) == 32'd0) ?
                          WHITE : BLACK;
            3'd7: rgb_d = {grey, grey, grey};
            default: rgb_d = BLACK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            cmd_meta_q    <= '0;
            cmd_sync_q    <= '0;
            mode_q        <= '0;
`ifdef VGA_PATTERN_SCROLL_EN
            frame_cnt_q   <= '0;
`endif
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            cmd_meta_q <= vga.cmd;
            cmd_sync_q <= cmd_meta_q;
            // Mode only switches at the top-left corner so a frame never mixes patterns.
            if (frame_first) begin
                mode_q <= cmd_sync_q;
            end
`ifdef VGA_PATTERN_SCROLL_EN
            if (frame_first) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
`endif
            hsync_q       <= h_sync_on ? SYNC_ON : ~SYNC_ON;
            vsync_q       <= v_sync_on ? SYNC_ON : ~SYNC_ON;
            de_q          <= act;
            rgb_q         <= act ? rgb_d : BLACK;
            pix_x_q       <= x_d;
            pix_y_q       <= y_d;
            frame_start_q <= frame_first;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.vga_r       = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign vga.vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga.vga_b       = rgb_q[COLOR_W-1 -: COLOR_W];
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.frame_start = frame_start_q;
    assign vga.led         = mode_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised successor to the lab VGA controller. Generates programmable-timing VGA sync plus a selectable test pattern at any colour depth.
- cmd is synchronised and applied only at frame boundaries, so mode changes never tear the picture.
- All outputs are registered and phase-aligned, with active-pixel coordinates exported.
- Sits between the pixel-clock domain and the board VGA DAC pins; the switches drive cmd and the LEDs mirror the active mode.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- COLOR_W, 4, bits per colour channel
- SYNC_POL, 0, sync pulse level (0 = active-low, 1 = active-high)
- CELL_LOG2, 5, checkerboard cell size = 2^CELL_LOG2 pixels

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- cmd  in  3  pattern select, asynchronous (switches)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video enable
- vga_r / vga_g / vga_b  out  COLOR_W each  colour channels
- pix_x  out  clog2(H_ACTIVE)  active x coordinate, 0 in blanking
- pix_y  out  clog2(V_ACTIVE)  active y coordinate, 0 in blanking
- frame_start  out  1  one-cycle pulse at the first sync cycle of each frame
- led  out  3  currently applied mode

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise. Line order: sync, back porch, active, front porch.
- hcount runs 0..H_TOTAL-1 and wraps to 0.
- vcount increments when hcount == H_TOTAL-1, and wraps to 0 only when hcount == H_TOTAL-1 && vcount == V_TOTAL-1. No early wrap is allowed.
- Counter values decode as:
  - hsync_active: hcount < H_SYNC; vsync_active: vcount < V_SYNC.
  - active: H_SYNC+H_BACK <= hcount < H_SYNC+H_BACK+H_ACTIVE, and the same form vertically.
  - pix_x = hcount-(H_SYNC+H_BACK), pix_y likewise.
- Latency: every output is registered from the counter values of cycle t and appears at t+1, so hsync, vsync, de, rgb, pix_x/y and frame_start stay mutually aligned.
- cmd goes through a 2-flop synchroniser. mode_reg loads the synchronised cmd only when hcount == 0 && vcount == 0. A change mid-frame takes effect at the next frame. led = mode_reg.
- FULL means all ones on COLOR_W bits. White = FULL,FULL,FULL.
- Modes (all modes output rgb = 0 whenever de = 0):
  - 0: white
  - 1: red
  - 2: green
  - 3: blue
  - 4: four vertical bars of width H_ACTIVE/4, ordered red, blue, green, white; any remainder pixels are white.
  - 5: four horizontal bands of height V_ACTIVE/4, same colour order; any remainder lines are white.
  - 6: checkerboard; white when pix_x[CELL_LOG2] XOR pix_y[CELL_LOG2] == 0, else black.
  - 7: grey ramp; each channel = pix_x[MSB -: COLOR_W], with pix_x zero-extended when it is narrower than COLOR_W.
- frame_counter (16 bit) increments at each frame start and wraps from 0xFFFF to 0.
- Reset (asynchronous, at any point mid-frame):
  - hcount, vcount, mode_reg, synchroniser, frame_counter and led all go to 0.
  - hsync and vsync go to their inactive level (!SYNC_POL active level).
  - de, rgb, pix_x, pix_y and frame_start all go to 0.
- After reset release: the first edge has hcount = 0, so the registered sync asserts and frame_start pulses on the second edge.

Optional Feature:
- Macro VGA_PATTERN_SCROLL_EN.
- Defined: modes 4 and 6 use x_eff = (pix_x + frame_counter[7:0]) mod H_ACTIVE in place of pix_x, so the pattern scrolls 1 pixel per frame. All other modes are unchanged.
- Undefined: there is no scroll logic, frame_counter is omitted, and the patterns are static. Sync and de timing are identical with or without the macro.

Test Plan:
- Defaults, mode 0, two frames:
  - hsync low for 96 cycles every 800 cycles; vsync low for 1600 cycles (2 lines) every 420000 cycles.
  - de high for 640 consecutive cycles on each of 480 lines per frame.
  - frame_start period is 420000 cycles.
- cmd 1→4 switched at line 200: stays red until the next frame_start, then vertical bars appear; led reads 4 from that frame.
- Mode 4 bar edges: pix_x 159 is red and 160 is blue; 319/320 is blue/green; 479/480 is green/white. With de = 0, rgb = 0.
- Mode 6 with CELL_LOG2 = 5: pixel (31,0) is white, (32,0) black, (32,32) white.
- Reset asserted at hcount 300, line 100: all outputs go to their reset values immediately. After release, hsync asserts on the 2nd edge and frame_start pulses once.
- COLOR_W = 8, SYNC_POL = 1, scroll macro defined, mode 4: sync pulses are high, white is 0xFF. In frame n, the red/blue boundary sits at pix_x = (160 - n) mod 640.
